// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator for a {addr[6:0], rw, data[7:0]} frame, MSB first.
// Define SPI_MASTER_MISO_SYNC_EN to add a 2-flop miso synchroniser (needs CLK_DIV >= 3).
module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);
    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [14:0]      tx_q, tx_d;
    logic             rd_q, rd_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cap_c, cap_fire, cap_bit;

    // Rising sclk edge of a data-phase bit (bits 8..15)
    assign cap_c = (state_q == SHIFT) && (cnt_q == '0) && !sclk_q && bit_q[3];

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic miso_s1_q, miso_s2_q, cap_p1_q, cap_p2_q;

    // Capture strobe is delayed to line up with the synchronised miso
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            cap_p1_q  <= 1'b0;
            cap_p2_q  <= 1'b0;
        end else begin
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
            cap_p1_q  <= cap_c;
            cap_p2_q  <= cap_p1_q;
        end
    end

    assign cap_fire = cap_p2_q;
    assign cap_bit  = miso_s2_q;
`else
    assign cap_fire = cap_c;
    assign cap_bit  = miso;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rd_q    <= 1'b0;
            rx_q    <= '0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rd_d    = rd_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (cap_fire) begin
            rx_d = {rx_q[6:0], cap_bit};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    // addr[6] goes straight to mosi; the rest waits in tx_q
                    tx_d    = {addr[5:0], rw, rw ? 8'h00 : wdata};
                    rd_d    = rw;
                    mosi_d  = addr[6];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_MAX;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b1;
                    bit_d   = '0;
                    cnt_d   = CNT_MAX;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        mosi_d = tx_q[14];
                        tx_d   = {tx_q[13:0], 1'b0};
                        if (bit_q == 4'd15) begin
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = CNT_MAX;
                    state_d = GAP;
                    if (rd_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized self-checking bench for spi_master with a behavioural SPI slave
// and a cycle-timeline reference model; exercises a CLK_DIV=4 and a small-divider instance.
module tb_spi_master;
    localparam int CD0 = 4;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int CD1 = 3;
`else
    localparam int CD1 = 2;
`endif

    logic       clk = 1'b0;
    logic       reset, start, rw, sel;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       miso = 1'b0;
    logic       start0, start1;
    logic       busy0, done0, sclk0, cs0, mosi0;
    logic       busy1, done1, sclk1, cs1, mosi1;
    logic [7:0] rdata0, rdata1;
    logic       cur_busy, cur_done, cur_sclk, cur_cs, cur_mosi;
    logic [7:0] cur_rdata;

    int         ncmp = 0;
    int         nerr = 0;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] rdata_exp [2];
    int         gap_run = 0;
    int         falls = 0;
    logic       cs_prev = 1'b1;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    spi_master #(.CLK_DIV(CD0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy0), .done(done0), .rdata(rdata0), .sclk(sclk0), .cs(cs0), .mosi(mosi0),
        .miso(miso)
    );

    spi_master #(.CLK_DIV(CD1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .rdata(rdata1), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
        .miso(miso)
    );

    assign cur_busy  = sel ? busy1  : busy0;
    assign cur_done  = sel ? done1  : done0;
    assign cur_sclk  = sel ? sclk1  : sclk0;
    assign cur_cs    = sel ? cs1    : cs0;
    assign cur_mosi  = sel ? mosi1  : mosi0;
    assign cur_rdata = sel ? rdata1 : rdata0;

    // Slave: after the 8th..15th falling sclk edge present slave_byte MSB first, junk otherwise
    always @(negedge cur_sclk or cur_cs) begin
        if (cur_cs !== cs_prev) begin
            cs_prev = cur_cs;
            falls   = 0;
            miso    = 1'($urandom);
        end else if (!cur_cs && !cur_sclk) begin
            falls++;
            if (falls >= 8 && falls <= 15) miso = slave_byte[3'(15 - falls)];
            else                           miso = 1'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer; checks every cycle after E0 up to stop_n (negative = full 34*CLK_DIV)
    task automatic xfer(input logic r, input logic [6:0] a, input logic [7:0] wd,
                        input logic [7:0] sb, input bit hold, input bit scr,
                        input bit chained, input int stop_n);
        int          cd, last, k;
        logic [15:0] fr;
        cd   = sel ? CD1 : CD0;
        last = (stop_n < 0) ? 34 * cd : stop_n;
        fr   = {a, r, r ? 8'h00 : wd};
        slave_byte = sb;
        @(negedge clk);
        start = 1'b1; rw = r; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int n = 0; n <= last; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (scr) begin
                rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
            end
            if (n == 0 && chained) chk("cs_gap", 8'(gap_run), 8'(cd + 1));
            if (cur_cs) gap_run++;
            else        gap_run = 0;
            if (n == 33 * cd && r) rdata_exp[sel] = sb;
            chk("sclk", 8'(cur_sclk), 8'(n >= cd && n < 32 * cd && ((n / cd) % 2) == 1));
            chk("cs",   8'(cur_cs),   8'(n >= 33 * cd));
            chk("busy", 8'(cur_busy), 8'(n < 34 * cd));
            chk("done", 8'(cur_done), 8'(n == 33 * cd));
            chk("rdata", cur_rdata, rdata_exp[sel]);
            if (n >= cd && n < 32 * cd && (n % cd) == 0 && ((n / cd) % 2) == 1) begin
                k = (n / cd - 1) / 2;
                chk("mosi_bit", 8'(cur_mosi), 8'(fr[4'(15 - k)]));
            end
            if (n >= 33 * cd) chk("mosi_idle", 8'(cur_mosi), 8'h00);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        rdata_exp[0] = 8'h00;
        rdata_exp[1] = 8'h00;
        #2 reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_cs",    8'(cur_cs),   8'h01);
            chk("rst_sclk",  8'(cur_sclk), 8'h00);
            chk("rst_mosi",  8'(cur_mosi), 8'h00);
            chk("rst_busy",  8'(cur_busy), 8'h00);
            chk("rst_done",  8'(cur_done), 8'h00);
            chk("rst_rdata", cur_rdata,    8'h00);
        end
        sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Directed write and read from the plan
        xfer(1'b0, 7'h2A, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b0, -1);
        xfer(1'b1, 7'h15, 8'h00, 8'hA3, 1'b0, 1'b0, 1'b1, -1);

        // Random transfers with inputs scrambled while busy
        for (int i = 0; i < 6; i++) begin
            xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1, -1);
        end

        // start held high across back-to-back frames
        xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1, -1);
        xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1, -1);
        xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1, -1);

        // Reset in the middle of bit 9 of a read, then a normal write
        xfer(1'b1, 7'($urandom), 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
        xfer(1'b1, 7'($urandom), 8'h00, 8'h5C, 1'b0, 1'b0, 1'b1, CD0 * 19 + 2);
        #2 reset = 1'b1;
        #1;
        rdata_exp[0] = 8'h00;
        chk("mid_rst_cs",    8'(cur_cs),   8'h01);
        chk("mid_rst_sclk",  8'(cur_sclk), 8'h00);
        chk("mid_rst_busy",  8'(cur_busy), 8'h00);
        chk("mid_rst_done",  8'(cur_done), 8'h00);
        chk("mid_rst_mosi",  8'(cur_mosi), 8'h00);
        chk("mid_rst_rdata", cur_rdata,    8'h00);
        @(negedge clk) reset = 1'b0;
        xfer(1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0, -1);

        // Small-divider instance
        sel = 1'b1;
        xfer(1'b1, 7'h33, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
